// File: rtl/ilkn_lat_pkg.sv
// ilkn_lat_pkg: header layout and FSM state encoding shared by the RX latency monitor
package ilkn_lat_pkg;
  localparam logic [7:0] ILKN_MAGIC = 8'hA5;
  localparam int MAGIC_LSB  = 56;
  localparam int MSG_ID_LSB = 52;
  localparam int MSG_ID_W   = 4;
  localparam int SEQ_LSB    = 32;
  localparam int SEQ_W      = 16;
  localparam int TS_LSB     = 0;
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;
endpackage

// File: rtl/ilkn_lat_stats.sv
// ilkn_lat_stats: min/max/saturating sum/count of committed latencies with clear priority
module ilkn_lat_stats #(
  parameter int TS_W  = 32,
  parameter int SUM_W = 48,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [TS_W-1:0]  lat,
  output logic [TS_W-1:0]  lat_min,
  output logic [TS_W-1:0]  lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [CNT_W-1:0] pkt_cnt
);
  logic [SUM_W:0] sum_ext;
  assign sum_ext = {1'b0, lat_sum} + (SUM_W+1)'(lat);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clear) begin
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
      pkt_cnt <= '0;
    end else if (valid) begin
      lat_min <= lat < lat_min ? lat : lat_min;
      lat_max <= lat > lat_max ? lat : lat_max;
      lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      pkt_cnt <= &pkt_cnt ? pkt_cnt : pkt_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/ilkn_rx_latency_monitor.sv
// ilkn_rx_latency_monitor: parses RX test packets, measures one-way latency and tracks errors/statistics
module ilkn_rx_latency_monitor
  import ilkn_lat_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int SUM_W   = 48,
  parameter int NUM_MSG = 9
) (
  input  logic                init_clk,
  input  logic                clk_reset_n,
  input  logic [TS_W-1:0]     ts_now,
  input  logic                rx_ena,
  input  logic                rx_sop,
  input  logic                rx_eop,
  input  logic                rx_err,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                stat_clear,
  output logic [NUM_MSG-1:0]  recv_msg,
  output logic                lat_valid,
  output logic [TS_W-1:0]     lat_value,
  output logic [MSG_ID_W-1:0] lat_msg_id,
  output logic [TS_W-1:0]     lat_min,
  output logic [TS_W-1:0]     lat_max,
  output logic [SUM_W-1:0]    lat_sum,
  output logic [31:0]         pkt_cnt,
  output logic [15:0]         hdr_err_cnt,
  output logic [15:0]         seq_err_cnt
);
  state_e state, state_nxt;
  logic sop, eop, hdr_ok, commit, framing, rx_err_hit;
  logic [MSG_ID_W-1:0] id_f, id_q, c_id;
  logic [SEQ_W-1:0] seq_f, seq_q, c_seq, exp_seq;
  logic [TS_W-1:0] lat_f, lat_q, c_lat;
  logic [1:0] hdr_inc;
  logic [16:0] hdr_nxt;
  logic unused_rsvd;
  assign unused_rsvd = ^rx_data[MSG_ID_LSB-1:SEQ_LSB+SEQ_W];
  assign sop = rx_ena & rx_sop;
  assign eop = rx_ena & rx_eop;
  assign id_f = rx_data[MSG_ID_LSB +: MSG_ID_W];
  assign seq_f = rx_data[SEQ_LSB +: SEQ_W];
  assign lat_f = ts_now - rx_data[TS_LSB +: TS_W];
  assign hdr_ok = rx_data[MAGIC_LSB +: 8] == ILKN_MAGIC && id_f != '0 && int'(id_f) <= NUM_MSG;
  // A SOP word always restarts parsing, so a single-word packet is judged from the live header fields.
  always_comb begin
    framing = sop && state != IDLE;
    commit = eop & ~rx_err & (sop ? hdr_ok : state == BODY);
    rx_err_hit = eop & rx_err & (sop ? hdr_ok : state == BODY);
    c_id = sop ? id_f : id_q;
    c_seq = sop ? seq_f : seq_q;
    c_lat = sop ? lat_f : lat_q;
    state_nxt = sop ? (rx_eop ? IDLE : hdr_ok ? BODY : DROP) : eop ? IDLE : state;
    hdr_inc = 2'(framing) + 2'(sop & ~hdr_ok) + 2'(rx_err_hit);
    hdr_nxt = {1'b0, hdr_err_cnt} + 17'(hdr_inc);
  end
  always_ff @(posedge init_clk or negedge clk_reset_n)
    if (!clk_reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge init_clk or negedge clk_reset_n)
    if (!clk_reset_n) begin
      id_q <= '0;
      seq_q <= '0;
      lat_q <= '0;
      exp_seq <= '0;
      lat_valid <= 1'b0;
      recv_msg <= '0;
      lat_value <= '0;
      lat_msg_id <= '0;
      hdr_err_cnt <= '0;
      seq_err_cnt <= '0;
    end else begin
      if (sop) begin
        id_q <= id_f;
        seq_q <= seq_f;
        lat_q <= lat_f;
      end
      if (commit) begin
        exp_seq <= c_seq + 1'b1;
        lat_value <= c_lat;
        lat_msg_id <= c_id;
      end
      lat_valid <= commit;
      recv_msg <= commit ? NUM_MSG'(1) << (c_id - 1'b1) : '0;
      hdr_err_cnt <= stat_clear ? '0 : hdr_nxt[16] ? '1 : hdr_nxt[15:0];
      seq_err_cnt <= stat_clear ? '0 :
                     commit && c_seq != exp_seq && !(&seq_err_cnt) ? seq_err_cnt + 1'b1 : seq_err_cnt;
    end
  ilkn_lat_stats #(.TS_W(TS_W), .SUM_W(SUM_W), .CNT_W(32)) u_stats (
    .clk     (init_clk),
    .rst_n   (clk_reset_n),
    .clear   (stat_clear),
    .valid   (lat_valid),
    .lat     (lat_value),
    .lat_min (lat_min),
    .lat_max (lat_max),
    .lat_sum (lat_sum),
    .pkt_cnt (pkt_cnt)
  );
endmodule
